// File: rtl/engine_memory_response_merger_pkg.sv
// Shared types for the engine/memory response merger: packet layouts,
// FIFO status bundles, the merger state encoding and the two data mappings.
package engine_memory_response_merger_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int SRC_W      = 8;
    localparam int NUM_FIELDS = 4;

    typedef enum logic [1:0] {
        CMD_INVALID     = 2'd0,
        CMD_MEM_READ    = 2'd1,
        CMD_MEM_WRITE   = 2'd2,
        CMD_ENGINE_DATA = 2'd3
    } type_cmd;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        RUN   = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } type_merger_state;

    typedef struct packed {
        logic [SRC_W-1:0] sequence_source;
    } EngineRoute;

    typedef struct packed {
        type_cmd cmd;
    } EngineSubclass;

    typedef struct packed {
        EngineRoute        route;
        logic [ADDR_W-1:0] address;
        EngineSubclass     subclass;
    } EngineMeta;

    typedef struct packed {
        logic [NUM_FIELDS-1:0][DATA_W-1:0] field;
    } EngineData;

    typedef struct packed {
        EngineMeta meta;
        EngineData data;
    } EnginePayload;

    typedef struct packed {
        logic         valid;
        EnginePayload payload;
    } EnginePacket;

    typedef struct packed {
        logic [SRC_W-1:0]  packet_source;
        logic [ADDR_W-1:0] address;
        type_cmd           cmd;
    } MemoryMeta;

    typedef struct packed {
        logic [DATA_W-1:0] field;
    } MemoryData;

    typedef struct packed {
        MemoryMeta meta;
        MemoryData data;
    } MemoryPayload;

    typedef struct packed {
        logic         valid;
        MemoryPayload payload;
    } MemoryPacket;

    typedef struct packed {
        logic empty;
        logic prog_full;
    } FIFOStateSignalsOutput;

    typedef struct packed {
        logic rd_en;
    } FIFOStateSignalsInput;

    // Engine request -> memory request: the tag travels as packet_source and
    // only the first data word goes to memory.
    function automatic MemoryPayload map_engine_to_memory(input EnginePayload req);
        MemoryPayload m;
        m.meta.packet_source = req.meta.route.sequence_source;
        m.meta.address       = req.meta.address;
        m.meta.cmd           = req.meta.subclass.cmd;
        m.data.field         = req.data.field[0];
        return m;
    endfunction

    // Rebuild the engine packet: response word lands in field[0] and the
    // original words shift up by one; the top original word falls off.
    function automatic EnginePayload merge_response(input EnginePayload head,
                                                    input logic [DATA_W-1:0] rdata);
        EnginePayload e;
        e = head;
        e.meta.subclass.cmd = CMD_ENGINE_DATA;
        e.data.field[0]     = rdata;
        for (int i = 1; i < NUM_FIELDS; i++) begin
            e.data.field[i] = head.data.field[i-1];
        end
        return e;
    endfunction

endpackage

// File: rtl/engine_memory_response_merger_fifo.sv
// Generic synchronous first-word-fall-through FIFO: dout always shows the
// head entry; pushes when full and pops when empty are ignored.
module fifo_sync_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array carries data only, so it is never reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/engine_memory_response_merger.sv
// Forwards engine requests to memory, remembers each original payload in
// order, and merges the in-order memory responses back into engine packets.
// A shared credit pool sized to the output FIFO keeps responses lossless.
module engine_memory_response_merger
    import engine_memory_response_merger_pkg::*;
#(
    parameter int PENDING_DEPTH    = 16,
    parameter int OUT_DEPTH        = 16,
    parameter int PROG_FULL_MARGIN = 4
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    input  logic                  start_in,
    input  logic                  done_in,
    input  EnginePacket           engine_request_in,
    output FIFOStateSignalsOutput fifo_request_signals_out,
    output MemoryPacket           memory_request_out,
    input  logic                  memory_request_prog_full_in,
    input  MemoryPacket           memory_response_in,
    output EnginePacket           engine_response_out,
    input  FIFOStateSignalsInput  fifo_response_signals_in,
    output FIFOStateSignalsOutput fifo_response_signals_out,
    output logic                  done_out,
    output logic                  error_out
);

    localparam int PCW = $clog2(PENDING_DEPTH) + 1;
    localparam int OCW = $clog2(OUT_DEPTH) + 1;

    type_merger_state state;

    logic [PCW-1:0] pend_count;
    logic           pend_full;
    logic           pend_empty;
    EnginePayload   pend_head;

    logic [OCW-1:0] out_count;
    logic           out_full;
    logic           out_empty;
    EnginePayload   out_head;

    logic [31:0]    credits;
    logic           running;
    logic           resp_active;
    logic           accept;
    logic           req_loss;
    logic           resp_merge;
    logic           resp_orphan;
    logic           resp_mismatch;
    logic           out_pop;
    EnginePayload   merged;

    logic           req_vld_p1;
    MemoryPayload   req_payload_p1;
    logic           error_r;
    logic           resp_unused;

    // Every request in the pending queue owns an output slot in advance.
    assign credits     = 32'(OUT_DEPTH) - 32'(pend_count) - 32'(out_count);
    assign running     = (state == RUN);
    assign resp_active = (state == RUN) || (state == DRAIN);

    assign accept = running && engine_request_in.valid && (credits != 32'd0)
                    && !pend_full && !memory_request_prog_full_in;
    assign req_loss = engine_request_in.valid && !accept;

    // Responses outside RUN/DRAIN are stale (e.g. after reset) and dropped quietly.
    assign resp_merge    = resp_active && memory_response_in.valid && !pend_empty;
    assign resp_orphan   = resp_active && memory_response_in.valid && pend_empty;
    assign resp_mismatch = resp_merge && (memory_response_in.payload.meta.packet_source
                                          != pend_head.meta.route.sequence_source);

    assign merged  = merge_response(pend_head, memory_response_in.payload.data.field);
    assign out_pop = fifo_response_signals_in.rd_en && !out_empty;

    // Response address/cmd and the top original word are not part of the merge.
    assign resp_unused = ^{memory_response_in.payload.meta.address,
                           memory_response_in.payload.meta.cmd,
                           pend_head.data.field[NUM_FIELDS-1]};

    fifo_sync_fwft #(
        .WIDTH ($bits(EnginePayload)),
        .DEPTH (PENDING_DEPTH)
    ) u_pend_fifo (
        .clk   (ap_clk),
        .rst   (areset),
        .wr_en (accept),
        .din   (engine_request_in.payload),
        .rd_en (resp_merge),
        .dout  (pend_head),
        .full  (pend_full),
        .empty (pend_empty),
        .count (pend_count)
    );

    fifo_sync_fwft #(
        .WIDTH ($bits(EnginePayload)),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (ap_clk),
        .rst   (areset),
        .wr_en (resp_merge),
        .din   (merged),
        .rd_en (out_pop),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    // Control: state machine, request-valid stage and sticky error flag.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state      <= IDLE;
            req_vld_p1 <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            req_vld_p1 <= accept;
            if (req_loss || resp_orphan || resp_mismatch || (resp_merge && out_full)) begin
                error_r <= 1'b1;
            end
            case (state)
                IDLE:    if (start_in) state <= RUN;
                RUN:     if (done_in) state <= DRAIN;
                DRAIN:   if (pend_empty && out_empty) state <= DONE;
                DONE:    if (start_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage p1: mapped memory request, data captured only on accept ----
    always_ff @(posedge ap_clk) begin
        if (accept) req_payload_p1 <= map_engine_to_memory(engine_request_in.payload);
    end

    assign memory_request_out  = '{valid: req_vld_p1, payload: req_payload_p1};
    assign engine_response_out = '{valid: !out_empty, payload: out_head};

    assign fifo_request_signals_out = '{
        empty:     pend_empty,
        prog_full: (credits <= 32'(PROG_FULL_MARGIN))
    };
    assign fifo_response_signals_out = '{
        empty:     out_empty,
        prog_full: ((32'(OUT_DEPTH) - 32'(out_count)) <= 32'(PROG_FULL_MARGIN))
    };

    assign done_out  = (state == DONE);
    assign error_out = error_r;

endmodule

// File: tb/tb_engine_memory_response_merger.sv
// Directed bench for engine_memory_response_merger: table of round-trip
// vectors plus hand-written burst, credit, error, drain and reset sequences.
module tb_engine_memory_response_merger;
    import engine_memory_response_merger_pkg::*;

    logic                  ap_clk = 1'b0;
    logic                  areset;
    logic                  start_in;
    logic                  done_in;
    EnginePacket           engine_request_in;
    FIFOStateSignalsOutput fifo_request_signals_out;
    MemoryPacket           memory_request_out;
    logic                  memory_request_prog_full_in;
    MemoryPacket           memory_response_in;
    EnginePacket           engine_response_out;
    FIFOStateSignalsInput  fifo_response_signals_in;
    FIFOStateSignalsOutput fifo_response_signals_out;
    logic                  done_out;
    logic                  error_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  src;
        logic [31:0] addr;
        type_cmd     cmd;
        logic [31:0] f0, f1, f2, f3;
        logic [7:0]  rsrc;
        logic [31:0] rdata;
        logic [31:0] exp_mdata;
        logic [31:0] exp_o0, exp_o1, exp_o2, exp_o3;
        logic        exp_err;
    } vec_t;

    vec_t vecs[4];

    engine_memory_response_merger #(
        .PENDING_DEPTH    (16),
        .OUT_DEPTH        (16),
        .PROG_FULL_MARGIN (4)
    ) dut (
        .ap_clk                      (ap_clk),
        .areset                      (areset),
        .start_in                    (start_in),
        .done_in                     (done_in),
        .engine_request_in           (engine_request_in),
        .fifo_request_signals_out    (fifo_request_signals_out),
        .memory_request_out          (memory_request_out),
        .memory_request_prog_full_in (memory_request_prog_full_in),
        .memory_response_in          (memory_response_in),
        .engine_response_out         (engine_response_out),
        .fifo_response_signals_in    (fifo_response_signals_in),
        .fifo_response_signals_out   (fifo_response_signals_out),
        .done_out                    (done_out),
        .error_out                   (error_out)
    );

    always #5 ap_clk = ~ap_clk;

    // Output FIFO must never be pushed while full.
    always @(posedge ap_clk) begin
        assert (areset || !(dut.resp_merge && dut.out_full)) else begin
            failures++;
            $display("FAIL out_fifo_overflow push while full at %0t", $time);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic EnginePacket mk_req(input logic [7:0] src, input logic [31:0] addr,
                                           input type_cmd cmd, input logic [31:0] f0,
                                           input logic [31:0] f1, input logic [31:0] f2,
                                           input logic [31:0] f3);
        EnginePacket p;
        p = '0;
        p.valid                              = 1'b1;
        p.payload.meta.route.sequence_source = src;
        p.payload.meta.address               = addr;
        p.payload.meta.subclass.cmd          = cmd;
        p.payload.data.field[0]              = f0;
        p.payload.data.field[1]              = f1;
        p.payload.data.field[2]              = f2;
        p.payload.data.field[3]              = f3;
        return p;
    endfunction

    function automatic MemoryPacket mk_resp(input logic [7:0] src, input logic [31:0] d);
        MemoryPacket m;
        m = '0;
        m.valid                      = 1'b1;
        m.payload.meta.packet_source = src;
        m.payload.data.field         = d;
        return m;
    endfunction

    task automatic clear_inputs();
        start_in                       = 1'b0;
        done_in                        = 1'b0;
        engine_request_in              = '0;
        memory_request_prog_full_in    = 1'b0;
        memory_response_in             = '0;
        fifo_response_signals_in.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    initial begin
        int k;

        vecs[0] = '{8'h01, 32'h0000_1000, CMD_MEM_READ, 32'hA, 32'hB, 32'hC, 32'hD,
                    8'h01, 32'h55, 32'hA, 32'h55, 32'hA, 32'hB, 32'hC, 1'b0};
        vecs[1] = '{8'h7F, 32'hDEAD_BEEF, CMD_MEM_WRITE, 32'h1111_1111, 32'h2222_2222,
                    32'h3333_3333, 32'h4444_4444, 8'h7F, 32'hFFFF_FFFF, 32'h1111_1111,
                    32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0};
        vecs[2] = '{8'h00, 32'h0, CMD_ENGINE_DATA, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF,
                    8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vecs[3] = '{8'h01, 32'h0000_0020, CMD_MEM_READ, 32'h5, 32'h6, 32'h7, 32'h8,
                    8'h02, 32'h9, 32'h5, 32'h9, 32'h5, 32'h6, 32'h7, 1'b1};

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_done",       32'(done_out), 32'd0);
        chk("rst_error",      32'(error_out), 32'd0);
        chk("rst_mreq_vld",   32'(memory_request_out.valid), 32'd0);
        chk("rst_eresp_vld",  32'(engine_response_out.valid), 32'd0);
        chk("rst_req_empty",  32'(fifo_request_signals_out.empty), 32'd1);
        chk("rst_req_pf",     32'(fifo_request_signals_out.prog_full), 32'd0);
        chk("rst_resp_empty", 32'(fifo_response_signals_out.empty), 32'd1);
        chk("rst_resp_pf",    32'(fifo_response_signals_out.prog_full), 32'd0);

        // ---------------- table-driven round trips ----------------
        pulse_start();
        for (int v = 0; v < 4; v++) begin
            engine_request_in = mk_req(vecs[v].src, vecs[v].addr, vecs[v].cmd,
                                       vecs[v].f0, vecs[v].f1, vecs[v].f2, vecs[v].f3);
            step();
            engine_request_in = '0;
            chk("rt_mreq_vld",  32'(memory_request_out.valid), 32'd1);
            chk("rt_mreq_data", memory_request_out.payload.data.field, vecs[v].exp_mdata);
            chk("rt_mreq_src",  32'(memory_request_out.payload.meta.packet_source), 32'(vecs[v].src));
            chk("rt_mreq_addr", memory_request_out.payload.meta.address, vecs[v].addr);
            chk("rt_mreq_cmd",  32'(memory_request_out.payload.meta.cmd), 32'(vecs[v].cmd));
            step();
            memory_response_in = mk_resp(vecs[v].rsrc, vecs[v].rdata);
            step();
            memory_response_in = '0;
            chk("rt_mreq_pulse", 32'(memory_request_out.valid), 32'd0);
            chk("rt_out_vld", 32'(engine_response_out.valid), 32'd1);
            chk("rt_out_f0",  engine_response_out.payload.data.field[0], vecs[v].exp_o0);
            chk("rt_out_f1",  engine_response_out.payload.data.field[1], vecs[v].exp_o1);
            chk("rt_out_f2",  engine_response_out.payload.data.field[2], vecs[v].exp_o2);
            chk("rt_out_f3",  engine_response_out.payload.data.field[3], vecs[v].exp_o3);
            chk("rt_out_cmd", 32'(engine_response_out.payload.meta.subclass.cmd), 32'(CMD_ENGINE_DATA));
            chk("rt_out_src", 32'(engine_response_out.payload.meta.route.sequence_source), 32'(vecs[v].src));
            chk("rt_out_addr", engine_response_out.payload.meta.address, vecs[v].addr);
            fifo_response_signals_in.rd_en = 1'b1;
            step();
            fifo_response_signals_in.rd_en = 1'b0;
            chk("rt_out_empty", 32'(fifo_response_signals_out.empty), 32'd1);
            chk("rt_error", 32'(error_out), 32'(vecs[v].exp_err));
        end

        // ---------------- burst ordering ----------------
        do_reset();
        pulse_start();
        k = 0;
        for (int c = 0; c < 24; c++) begin
            if (c >= 1 && c <= 16) begin
                chk("burst_mreq_vld",  32'(memory_request_out.valid), 32'd1);
                chk("burst_mreq_data", memory_request_out.payload.data.field, 32'(c - 1));
            end
            if (engine_response_out.valid) begin
                if (k < 16) begin
                    chk("burst_out_f0", engine_response_out.payload.data.field[0], 32'(100 + k));
                    chk("burst_out_f1", engine_response_out.payload.data.field[1], 32'(k));
                end
                k++;
            end
            if (c < 16) engine_request_in = mk_req(8'h01, 32'(256 + c), CMD_MEM_READ,
                                                    32'(c), 32'h0, 32'h0, 32'h0);
            else        engine_request_in = '0;
            if (c >= 2 && c < 18) memory_response_in = mk_resp(8'h01, 32'(100 + c - 2));
            else                  memory_response_in = '0;
            fifo_response_signals_in.rd_en = 1'b1;
            step();
        end
        clear_inputs();
        chk("burst_count", 32'(k), 32'd16);
        chk("burst_error", 32'(error_out), 32'd0);

        // ---------------- credit stall ----------------
        do_reset();
        pulse_start();
        for (int c = 0; c < 16; c++) begin
            engine_request_in = mk_req(8'h01, 32'h0, CMD_MEM_READ, 32'(c), 32'h0, 32'h0, 32'h0);
            step();
            if (c == 10) chk("stall_pf_before", 32'(fifo_request_signals_out.prog_full), 32'd0);
            if (c == 11) chk("stall_pf_at_4",   32'(fifo_request_signals_out.prog_full), 32'd1);
        end
        engine_request_in = '0;
        for (int r = 0; r < 16; r++) begin
            memory_response_in = mk_resp(8'h01, 32'(200 + r));
            step();
        end
        memory_response_in = '0;
        chk("stall_pend_empty", 32'(fifo_request_signals_out.empty), 32'd1);
        chk("stall_out_pf",     32'(fifo_response_signals_out.prog_full), 32'd1);
        chk("stall_req_pf",     32'(fifo_request_signals_out.prog_full), 32'd1);
        chk("stall_head_f0",    engine_response_out.payload.data.field[0], 32'd200);
        chk("stall_err_before", 32'(error_out), 32'd0);
        engine_request_in = mk_req(8'h01, 32'h0, CMD_MEM_READ, 32'd16, 32'h0, 32'h0, 32'h0);
        step();
        engine_request_in = '0;
        chk("stall_17_refused", 32'(memory_request_out.valid), 32'd0);
        chk("stall_err_after",  32'(error_out), 32'd1);

        // ---------------- orphan response ----------------
        do_reset();
        pulse_start();
        memory_response_in = mk_resp(8'h01, 32'h77);
        step();
        memory_response_in = '0;
        chk("orphan_dropped", 32'(engine_response_out.valid), 32'd0);
        chk("orphan_error",   32'(error_out), 32'd1);
        step();
        step();
        step();
        chk("orphan_sticky",  32'(error_out), 32'd1);

        // ---------------- response racing first accept ----------------
        do_reset();
        pulse_start();
        engine_request_in  = mk_req(8'h03, 32'h0, CMD_MEM_READ, 32'h1, 32'h0, 32'h0, 32'h0);
        memory_response_in = mk_resp(8'h03, 32'h2);
        step();
        clear_inputs();
        chk("race_mreq_vld",   32'(memory_request_out.valid), 32'd1);
        chk("race_dropped",    32'(engine_response_out.valid), 32'd0);
        chk("race_error",      32'(error_out), 32'd1);
        chk("race_pend_nonempty", 32'(fifo_request_signals_out.empty), 32'd0);

        // ---------------- drain and done ----------------
        do_reset();
        pulse_start();
        for (int c = 0; c < 3; c++) begin
            engine_request_in = mk_req(8'h01, 32'h0, CMD_MEM_READ, 32'(c), 32'h0, 32'h0, 32'h0);
            step();
        end
        engine_request_in = '0;
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        engine_request_in = mk_req(8'h01, 32'h0, CMD_MEM_READ, 32'h9, 32'h0, 32'h0, 32'h0);
        step();
        engine_request_in = '0;
        chk("drain_refused", 32'(memory_request_out.valid), 32'd0);
        for (int r = 0; r < 3; r++) begin
            memory_response_in = mk_resp(8'h01, 32'(300 + r));
            step();
        end
        memory_response_in = '0;
        chk("drain_not_done_full", 32'(done_out), 32'd0);
        chk("drain_out_vld",       32'(engine_response_out.valid), 32'd1);
        for (int p = 0; p < 3; p++) begin
            fifo_response_signals_in.rd_en = 1'b1;
            step();
            fifo_response_signals_in.rd_en = 1'b0;
            if (p < 2) chk("drain_not_done", 32'(done_out), 32'd0);
        end
        for (int w = 0; w < 5 && !done_out; w++) step();
        chk("drain_done", 32'(done_out), 32'd1);
        pulse_start();
        chk("done_to_idle", 32'(done_out), 32'd0);

        // ---------------- reset mid-flight ----------------
        do_reset();
        pulse_start();
        for (int c = 0; c < 5; c++) begin
            engine_request_in = mk_req(8'h01, 32'h0, CMD_MEM_READ, 32'(c), 32'h0, 32'h0, 32'h0);
            step();
        end
        memory_request_prog_full_in = 1'b1;
        step();
        engine_request_in = '0;
        memory_request_prog_full_in = 1'b0;
        chk("mpf_refused", 32'(memory_request_out.valid), 32'd0);
        chk("mpf_error",   32'(error_out), 32'd1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        chk("mid_rst_mreq_vld",   32'(memory_request_out.valid), 32'd0);
        chk("mid_rst_eresp_vld",  32'(engine_response_out.valid), 32'd0);
        chk("mid_rst_req_empty",  32'(fifo_request_signals_out.empty), 32'd1);
        chk("mid_rst_resp_empty", 32'(fifo_response_signals_out.empty), 32'd1);
        chk("mid_rst_error",      32'(error_out), 32'd0);
        chk("mid_rst_done",       32'(done_out), 32'd0);
        memory_response_in = mk_resp(8'h01, 32'h44);
        step();
        memory_response_in = '0;
        chk("late_resp_dropped", 32'(engine_response_out.valid), 32'd0);
        chk("late_resp_no_err",  32'(error_out), 32'd0);
        engine_request_in = mk_req(8'h01, 32'h0, CMD_MEM_READ, 32'h1, 32'h0, 32'h0, 32'h0);
        step();
        engine_request_in = '0;
        chk("idle_refused", 32'(memory_request_out.valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/engine_memory_response_merger.md
Name: engine_memory_response_merger

Overview:
- Sits between an engine's memory-issue path and its memory channel, as the return side of the EnginePacket-to-MemoryPacket request mapping.
- Forward path: converts each accepted engine request into a memory request and parks the original engine payload in an in-order pending queue.
- Return path: merges each in-order memory response with the head pending payload, shifting the data fields, and emits the rebuilt EnginePacket.
- A credit counter guarantees that every response has output space, so the memory side never needs backpressure.

Parameters:
- PENDING_DEPTH, 16, pending-queue depth; power of 2, ≥2.
- OUT_DEPTH, 16, output-FIFO depth; also the total credit pool; power of 2, ≥2.
- PROG_FULL_MARGIN, 4; fifo_request_signals_out.prog_full asserts when free credits ≤ this value.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- start_in  in  1  pulse; leaves IDLE.
- done_in  in  1  pulse; requests drain.
- engine_request_in  in  $bits(EnginePacket)  valid + payload from the engine.
- fifo_request_signals_out  out  $bits(FIFOStateSignalsOutput)  empty = pending queue empty; prog_full = credit low.
- memory_request_out  out  $bits(MemoryPacket)  mapped request, registered.
- memory_request_prog_full_in  in  1  downstream memory cannot take more requests.
- memory_response_in  in  $bits(MemoryPacket)  in-order response, no backpressure.
- engine_response_out  out  $bits(EnginePacket)  merged packet, FWFT.
- fifo_response_signals_in  in  $bits(FIFOStateSignalsInput)  rd_en pops engine_response_out.
- fifo_response_signals_out  out  $bits(FIFOStateSignalsOutput)  output-FIFO state.
- done_out  out  1  high in DONE.
- error_out  out  1  sticky protocol error.

Behaviour:
- Reset (areset sampled high on a rising edge):
  - FSM goes to IDLE; both FIFOs and all counters are cleared.
  - All valids, done_out and error_out go to 0; both fifo-signal empty bits go to 1, prog_full bits to 0.
  - Reset mid-operation discards all in-flight state; late memory responses after reset are dropped.
- FSM states and transitions:
  - IDLE → RUN on start_in.
  - RUN → DRAIN on done_in.
  - DRAIN → DONE when the pending queue is empty and the output FIFO is empty.
  - DONE → IDLE on start_in.
- Request acceptance rules:
  - accept = RUN & engine_request_in.valid & credits > 0 & !pending_full & !memory_request_prog_full_in.
  - An input that is valid but not accepted is lost. Upstream must honour prog_full. Any loss sets error_out.
  - No acceptance in IDLE, DRAIN or DONE.
- Request mapping, on accept in cycle N: memory_request_out.valid = 1 in cycle N+1 (1-cycle latency, a single pulse per accept), with:
  - packet_source = sequence_source;
  - address copied unchanged;
  - cmd copied unchanged;
  - data.field = data.field[0];
  - the full engine payload is pushed to the pending queue.
- Credit accounting:
  - credits = OUT_DEPTH − pending_count − out_count.
  - An accept decrements credits; an rd_en pop increments them. Both in the same cycle leave credits unchanged.
- Response merge, on memory_response_in.valid in cycle M:
  - Pop the pending head and build the merged packet:
    - meta = head meta, with subclass.cmd = CMD_ENGINE_DATA;
    - field[0] = response data;
    - field[i] = head field[i−1], for i = 1..3.
  - Push the merged packet to the output FIFO.
  - engine_response_out.valid is seen in cycle M+1 when the output FIFO was empty.
- Response checks:
  - Response packet_source ≠ head sequence_source: still merge, and set error_out.
  - Response while the pending queue is empty: drop it and set error_out.
- Simultaneous events:
  - Accept and response in the same cycle: push and pop of the pending queue both occur, and the count is unchanged.
  - A response in the same cycle as an accept into an empty queue is an error, because the head is not yet visible.
- Output FIFO:
  - rd_en while empty is ignored.
  - Overflow is impossible by construction; a bench assertion must check this.
- Counter wrap: FIFO pointers wrap modulo depth; counts are $clog2(depth)+1 bits wide.

Decomposition:
- Shared package:
  - the credit/FSM state enum type_merger_state (IDLE, RUN, DRAIN, DONE; one-hot, 4 bits);
  - the mapping functions: engine→memory request, and response data shift.
- Sub-module: one generic synchronous FWFT FIFO, fifo_sync_fwft (parameters WIDTH, DEPTH; ports rd_en/wr_en/full/empty/count). It is instantiated twice: once for pending and once for output.

Test Plan:
- Single round trip:
  - Stimulus: start; one request with sequence_source=0x1, field[0]=0xA, field[1..3]=0xB,0xC,0xD; response data=0x55 two cycles later.
  - Required: memory_request_out.data=0xA in cycle N+1, and engine_response_out fields=0x55,0xA,0xB,0xC with cmd=CMD_ENGINE_DATA.
- Order under burst:
  - Stimulus: 16 back-to-back requests with field[0]=0..15, responses 100..115, rd_en held high.
  - Required: outputs in order, field[0]=100+i and field[1]=i.
- Credit stall:
  - Stimulus: rd_en=0, 16 requests, all responses returned, then a 17th request.
  - Required: 17th request not accepted; prog_full=1 once ≤4 credits remain; error_out=1 because valid was dropped.
- Protocol errors:
  - Stimulus 1: a response with the pending queue empty. Required: dropped, error_out=1 and stays 1.
  - Stimulus 2: a response with packet_source=0x2 against head 0x1. Required: merged, error_out=1.
- Drain and done:
  - Stimulus: 3 outstanding requests, done_in, then 3 responses and pops.
  - Required: done_out=1 only after the third pop; new requests are refused during DRAIN.
- Reset mid-flight:
  - Stimulus: areset with 5 pending requests.
  - Required: next cycle all valids=0, both empty bits=1, error_out=0, FSM in IDLE.
